wb_port_driver: RTL and testbench
=================================

# wb_port_driver

Write-side driver for the 32×32 integer register file's single write port (A3/WD3/WE3). Merges single-cycle ALU results with in-order, variable-latency load responses from data memory, tracks outstanding load destinations in a scoreboard, and exposes a hazard flag to the decode stage. Sits between execute/memory and the register file; the register file samples the write port on the falling edge of the same cycle this block presents it.

## Interface
- DEPTH, 4, maximum outstanding loads (power of two, ≥2)
- DATA_W, 32, result width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_rd  in  ADDR_W  ALU destination
- alu_result  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- ld_issue  in  1  load issued to memory
- ld_issue_rd  in  ADDR_W  load destination
- ld_ready  out  1  load issue accepted when ld_issue && ld_ready
- ld_resp_valid  in  1  load data returned (in issue order)
- ld_resp_data  in  DATA_W  load data
- q_rs1, q_rs2, q_rd  in  ADDR_W  decode-stage hazard query
- hazard  out  1  any queried nonzero register has a pending load
- A3  out  ADDR_W  register-file write address
- WD3  out  DATA_W  register-file write data
- WE3  out  1  register-file write enable
- err  out  1  sticky: load response with empty queue

## Operation
- Load queue: DEPTH-entry FIFO of destination addresses, pointers wrap modulo DEPTH, count 0..DEPTH.
- ld_ready = (count != DEPTH) && !pending[ld_issue_rd]. Uses current count; a same-cycle response does not free space for issue.
- Accepted issue: push rd; set pending[rd] unless rd == 0 (x0 entries still queued for ordering).
- ld_resp_valid with count > 0: pop head rd, register write (head rd, ld_resp_data); clear pending[head rd]. Simultaneous issue+response: both applied; count unchanged.
- ld_resp_valid with count == 0: ignored, err set until reset.
- Skid register: one entry (rd, data). alu_ready = !skid_full.
- Write-port priority each cycle: load response > skid > new ALU result.
  - Load response present: write load; accepted ALU result goes into skid.
  - No response, skid full: write skid, skid empties; alu_ready is low this cycle so no new ALU result.
  - No response, skid empty, ALU accepted: write ALU result directly.
- Writes with destination 0 drive WE3 = 0 (A3/WD3 don't-care).
- Scoreboard: pending[0] is hardwired 0. hazard = pending[q_rs1] | pending[q_rs2] | pending[q_rd], combinational from current state.

## Timing
- Reset: queue empty, skid empty, pending all 0, err = 0, A3 = 0, WD3 = 0, WE3 = 0; alu_ready = 1 and ld_ready = 1 in the first cycle after reset.
- A3/WD3/WE3 are registered. Result accepted in cycle N is driven in cycle N+1 and written at that cycle's falling edge.
- Load response in cycle N: write in cycle N+1; pending bit clear from N+1, so hazard drops in N+1.
- ALU result deferred by a colliding response: written in the first later cycle with no load response, at the earliest N+2.
- Issue in cycle N: pending and hazard visible from N+1.
- WE3 high for exactly one cycle per write; no writes dropped or duplicated.
- Reset mid-operation discards queued loads, the skid entry and pending bits; later responses set err.

## Test plan
- Reset, then alu_valid, rd=5, result=0x1234 -> next cycle A3=5, WD3=0x1234, WE3=1; following cycle WE3=0.
- Issue load rd=7; respond 3 cycles later with 0xDEADBEEF -> hazard=1 for q_rs1=7 until the write cycle; WE3=1, A3=7, WD3=0xDEADBEEF one cycle after the response.
- Load response for rd=3 (0xAA) in the same cycle as ALU rd=4 (0xBB) -> cycle+1 writes 3/0xAA, alu_ready=0; cycle+2 writes 4/0xBB; alu_ready=1 again.
- Issue 4 loads (rd 1,2,3,4) -> ld_ready=0; issue+response in the same cycle -> issue refused; responses 0x11..0x44 write r1..r4 in order.
- Issue load rd=9 then re-issue rd=9 -> second issue refused (ld_ready=0) until the first writes back; load to rd=0 -> no WE3, no hazard.
- Response with an empty queue -> err=1, no write; reset -> err=0, all outputs at reset values.

Source files
------------

// File: rtl/wb_port_driver.sv
// Register-file write-port driver: merges ALU results with in-order load
// responses, tracks outstanding load destinations and flags decode hazards.
module wb_port_driver #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_result,
  output logic              alu_ready,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_rd,
  output logic              ld_ready,
  input  logic              ld_resp_valid,
  input  logic [DATA_W-1:0] ld_resp_data,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  input  logic [ADDR_W-1:0] q_rd,
  output logic              hazard,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              err
);
  localparam int PW   = $clog2(DEPTH);
  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [ADDR_W-1:0] q_mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count;
  logic [NREG-1:0]   pending, pending_nxt;
  logic              skid_full;
  wr_t               skid;
  wr_t               alu_in, wsel;
  logic              wsel_vld, skid_load, skid_drain;
  logic              issue_acc, resp_acc, alu_acc;
  logic [ADDR_W-1:0] head_rd;

  assign head_rd   = q_mem[rptr];
  assign alu_in    = '{rd: alu_rd, data: alu_result};
  assign alu_ready = !skid_full;
  // Space is judged on the current count: a same-cycle response frees nothing.
  assign ld_ready  = (count != (PW+1)'(DEPTH)) && !pending[ld_issue_rd];
  assign issue_acc = ld_issue && ld_ready;
  assign resp_acc  = ld_resp_valid && (count != '0);
  assign alu_acc   = alu_valid && alu_ready;
  assign hazard    = pending[q_rs1] | pending[q_rs2] | pending[q_rd];

  // Port priority: load response, then skid, then a fresh ALU result.
  always_comb begin
    wsel       = alu_in;
    wsel_vld   = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (resp_acc) begin
      wsel      = '{rd: head_rd, data: ld_resp_data};
      wsel_vld  = 1'b1;
      skid_load = alu_acc;
    end else if (skid_full) begin
      wsel       = skid;
      wsel_vld   = 1'b1;
      skid_drain = 1'b1;
    end else if (alu_acc) begin
      wsel_vld = 1'b1;
    end
  end

  always_comb begin
    pending_nxt = pending;
    if (resp_acc) pending_nxt[head_rd] = 1'b0;
    if (issue_acc && ld_issue_rd != '0) pending_nxt[ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (issue_acc) q_mem[wptr] <= ld_issue_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      pending   <= '0;
      skid_full <= 1'b0;
      skid      <= '0;
      err       <= 1'b0;
      A3        <= '0;
      WD3       <= '0;
      WE3       <= 1'b0;
    end else begin
      if (issue_acc) wptr <= wptr + 1'b1;
      if (resp_acc)  rptr <= rptr + 1'b1;
      case ({issue_acc, resp_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      pending <= pending_nxt;
      if (ld_resp_valid && count == '0) err <= 1'b1;
      if (skid_load) begin
        skid_full <= 1'b1;
        skid      <= alu_in;
      end else if (skid_drain) begin
        skid_full <= 1'b0;
      end
      WE3 <= wsel_vld && (wsel.rd != '0);
      if (wsel_vld) begin
        A3  <= wsel.rd;
        WD3 <= wsel.data;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_driver.sv
// Directed bench for wb_port_driver: queue-based reference model compared
// every cycle, plus hand-computed expectations on the key scenarios.
module tb_wb_port_driver;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, ld_issue, ld_ready, ld_resp_valid;
  logic [4:0]  alu_rd, ld_issue_rd, q_rs1, q_rs2, q_rd, A3;
  logic [31:0] alu_result, ld_resp_data, WD3;
  logic        hazard, WE3, err;

  int checks = 0;
  int errors = 0;

  // Reference model state: outstanding load destinations in issue order.
  logic [4:0]  mq [$];
  bit          m_skid, m_err, m_we;
  logic [4:0]  m_srd, m_a3;
  logic [31:0] m_sdata, m_wd3;

  wb_port_driver #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_ready(ld_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hazard(hazard),
    .A3(A3), .WD3(WD3), .WE3(WE3), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit m_pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update();
    bit          lr, ar, hw;
    logic [4:0]  wr;
    logic [31:0] wd;
    if (rst) begin
      mq.delete();
      m_skid = 0; m_err = 0; m_we = 0; m_a3 = '0; m_wd3 = '0;
    end else begin
      lr = (mq.size() < 4) && !m_pend(ld_issue_rd);
      ar = !m_skid;
      hw = 0; wr = '0; wd = '0;
      if (ld_resp_valid && mq.size() == 0) m_err = 1;
      if (ld_resp_valid && mq.size() > 0) begin
        wr = mq.pop_front(); wd = ld_resp_data; hw = 1;
        if (alu_valid && ar) begin
          m_skid = 1; m_srd = alu_rd; m_sdata = alu_result;
        end
      end else if (m_skid) begin
        wr = m_srd; wd = m_sdata; hw = 1; m_skid = 0;
      end else if (alu_valid && ar) begin
        wr = alu_rd; wd = alu_result; hw = 1;
      end
      if (ld_issue && lr) mq.push_back(ld_issue_rd);
      m_we = hw && (wr != 5'd0);
      if (m_we) begin m_a3 = wr; m_wd3 = wd; end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      chk("m_alu_ready", alu_ready, !m_skid);
      chk("m_ld_ready", ld_ready, (mq.size() < 4) && !m_pend(ld_issue_rd));
      chk("m_hazard", hazard, m_pend(q_rs1) | m_pend(q_rs2) | m_pend(q_rd));
      chk("m_err", err, m_err);
      chk("m_we3", WE3, m_we);
      if (m_we) begin
        chk("m_a3", A3, m_a3);
        chk("m_wd3", WD3, m_wd3);
      end
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_result = '0;
    ld_issue = 0; ld_issue_rd = '0; ld_resp_valid = 0; ld_resp_data = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
  endtask

  initial begin
    m_skid = 0; m_err = 0; m_we = 0; m_a3 = '0; m_wd3 = '0; m_srd = '0; m_sdata = '0;
    rst = 1; idle();
    step(); step();
    chk("rst_a3", A3, 0); chk("rst_wd3", WD3, 0); chk("rst_we3", WE3, 0);
    chk("rst_err", err, 0); chk("rst_alu_ready", alu_ready, 1); chk("rst_ld_ready", ld_ready, 1);
    rst = 0;

    // Plain ALU write
    alu_valid = 1; alu_rd = 5'd5; alu_result = 32'h1234;
    step(); idle(); #1;
    chk("alu_we3", WE3, 1); chk("alu_a3", A3, 5); chk("alu_wd3", WD3, 32'h1234);
    step();
    chk("alu_we3_off", WE3, 0);

    // Load to r7, response three cycles later
    ld_issue = 1; ld_issue_rd = 5'd7;
    step(); idle(); q_rs1 = 5'd7; #1;
    chk("ld7_hazard", hazard, 1);
    step(); step();
    ld_resp_valid = 1; ld_resp_data = 32'hDEADBEEF; #1;
    chk("ld7_hazard_resp", hazard, 1);
    step(); ld_resp_valid = 0; #1;
    chk("ld7_hazard_clr", hazard, 0); chk("ld7_we3", WE3, 1);
    chk("ld7_a3", A3, 7); chk("ld7_wd3", WD3, 32'hDEADBEEF);
    step(); idle();

    // Response collides with an ALU result
    ld_issue = 1; ld_issue_rd = 5'd3;
    step(); idle(); step();
    ld_resp_valid = 1; ld_resp_data = 32'hAA;
    alu_valid = 1; alu_rd = 5'd4; alu_result = 32'hBB;
    step(); idle(); #1;
    chk("col_a3_ld", A3, 3); chk("col_wd3_ld", WD3, 32'hAA); chk("col_we3_ld", WE3, 1);
    chk("col_alu_ready_lo", alu_ready, 0);
    step();
    chk("col_a3_alu", A3, 4); chk("col_wd3_alu", WD3, 32'hBB); chk("col_we3_alu", WE3, 1);
    chk("col_alu_ready_hi", alu_ready, 1);

    // Fill the queue, then drain in order
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1; ld_issue_rd = 5'(i);
      step();
    end
    ld_issue_rd = 5'd5; ld_issue = 0; #1;
    chk("full_ld_ready", ld_ready, 0);
    for (int k = 0; k < 4; k++) begin
      ld_resp_valid = 1; ld_resp_data = 32'h11 * (k + 1);
      if (k == 0) begin
        ld_issue = 1; #1;
        chk("full_issue_resp_ld_ready", ld_ready, 0);
      end
      step(); ld_issue = 0; ld_resp_valid = 0; #1;
      chk("drain_we3", WE3, 1); chk("drain_a3", A3, k + 1);
      chk("drain_wd3", WD3, 32'h11 * (k + 1));
    end
    idle(); q_rs1 = 5'd5; #1;
    chk("refused_no_hazard", hazard, 0);
    step();

    // Duplicate destination blocked until write-back; x0 load
    idle(); ld_issue = 1; ld_issue_rd = 5'd9;
    step(); #1;
    chk("dup_ld_ready", ld_ready, 0);
    step();
    ld_resp_valid = 1; ld_resp_data = 32'h99; #1;
    chk("dup_ld_ready_resp", ld_ready, 0);
    step(); ld_issue = 0; ld_resp_valid = 0; #1;
    chk("dup_ld_ready_free", ld_ready, 1); chk("dup_a3", A3, 9); chk("dup_wd3", WD3, 32'h99);
    idle(); ld_issue = 1; ld_issue_rd = 5'd0;
    step(); idle(); #1;
    chk("x0_hazard", hazard, 0);
    ld_resp_valid = 1; ld_resp_data = 32'h55;
    step(); idle(); #1;
    chk("x0_we3", WE3, 0);
    step();

    // Response with empty queue, then reset clears err
    ld_resp_valid = 1; ld_resp_data = 32'h77;
    step(); idle(); #1;
    chk("empty_err", err, 1); chk("empty_we3", WE3, 0);
    step();
    chk("err_sticky", err, 1);
    ld_issue = 1; ld_issue_rd = 5'd6;
    step(); idle();
    rst = 1; step(); rst = 0; q_rs1 = 5'd6; #1;
    chk("rst2_err", err, 0); chk("rst2_a3", A3, 0); chk("rst2_wd3", WD3, 0);
    chk("rst2_we3", WE3, 0); chk("rst2_alu_ready", alu_ready, 1);
    chk("rst2_hazard", hazard, 0);
    ld_issue_rd = 5'd6; #1;
    chk("rst2_ld_ready", ld_ready, 1);
    ld_resp_valid = 1; ld_resp_data = 32'h66;
    step(); idle(); #1;
    chk("post_rst_err", err, 1); chk("post_rst_we3", WE3, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
